mult_arbiter: RTL and testbench
===============================

# mult_arbiter

Round-robin arbiter and sequencer sharing one 8x8 sequential multiplier (`mult`) among up to four requesters. It accepts operand pairs from requesters over a req/ack handshake and drives the multiplier's start/busy interface. It captures each 16-bit product and returns it with a per-requester done pulse. It sits between the multiplier and the core-side units that need multiplication, so those units never touch the multiplier directly.

## Interface

Parameters:
- `NREQ`, default 2: number of requesters; legal range 2..4.

Ports:
- `clk_in`  in  1  clock; all logic on the rising edge.
- `rst_in`  in  1  reset, synchronous, active-high; must be the same reset that drives `mult`.
- `req_in`  in  NREQ  request per requester; level, held with operands until ack.
- `a_in`  in  8*NREQ  packed multiplicands; requester i occupies bits [8i+7:8i].
- `b_in`  in  8*NREQ  packed multipliers, same packing.
- `ack_out`  out  NREQ  one-cycle pulse; operands of requester i accepted.
- `done_out`  out  NREQ  one-cycle pulse; `y_out` holds requester i's product.
- `y_out`  out  16  last captured product; held until the next done.
- `busy_out`  out  1  high whenever the FSM is not in IDLE.
- `mult_a_out`, `mult_b_out`  out  8 each  operands to `mult`.
- `mult_start_out`  out  1  start strobe to `mult`.
- `mult_busy_in`  in  1  `mult` busy flag.
- `mult_y_in`  in  16  `mult` product.

## Operation

- All outputs are registered. Reset values: all outputs are 0, state is IDLE, round-robin pointer `ptr` is 0.
- FSM states are IDLE, START and BUSY.
- **IDLE**
  - If any `req_in` bit is set and `mult_busy_in` is 0, select grant g: the first set request searching from `ptr` upward, wrapping modulo NREQ.
  - Register `mult_a_out`/`mult_b_out` from slice g and `mult_start_out<=1`.
  - Pulse `ack_out[g]<=1`, store g, set `ptr<=(g+1) mod NREQ`, and go to START.
  - If `mult_busy_in` is 1, IDLE does not launch.
- **START** (exactly one cycle): `mult_start_out<=0` and go to BUSY unconditionally.
- **BUSY**
  - Wait for `mult_busy_in==0`.
  - On that cycle, capture `y_out<=mult_y_in`, pulse `done_out[g]<=1`, and go to IDLE.
- `mult_a_out` and `mult_b_out` hold their values from launch until the next launch.
- Requester rules:
  - A requester keeps `req_in` and its operands stable until it sees ack, then may drop req.
  - A requester may re-request before its done; it is arbitrated like any other request.
  - Done pulses for a requester occur in the same order as its acks.
- Products are unsigned 8x8 to 16 bits, with no truncation.
- Fairness: while any other requester is pending, the same requester is never granted twice in a row.
- Reset mid-operation (any state): the next cycle is IDLE with all outputs 0. No done is issued for the aborted operation. `mult` is reset by the same `rst_in`.

## Timing

- Let edge E0 be the edge at which IDLE samples the request. The 10-cycle `mult` busy window then gives:
  - `ack_out[g]` high in the cycle after E0.
  - `mult_start_out` high for exactly that one cycle.
  - `mult_busy_in` high from E1 to E11.
  - `done_out[g]` and the new `y_out` visible after E12, i.e. 12-cycle latency.
- The next grant is sampled at E13 at the earliest: one multiplication per 13 cycles.
- A requester that drops req the cycle after ack cannot be double-granted, because the FSM is in START/BUSY at that point.
- `ack_out` and `done_out` never have more than one bit set. An ack and a done are never set in the same cycle.

## Test plan

- **Single request:** req_in[0], a=0x0C, b=0x0D. Expect `ack_out[0]` for 1 cycle; `done_out[0]` 12 cycles after the accepting edge; y_out=0x009C; `busy_out` falls with done.
- **Operand extremes:** 0xFF*0xFF → y_out=0xFE01. 0x00*0xA5 → 0x0000. 0x80*0x02 → 0x0100.
- **Simultaneous requests after reset:** req0 (0x03*0x05) and req1 (0x07*0x09) together. Expect req0 granted first (ptr=0) with y=0x000F; req1 acked 13 cycles later with y=0x003F.
- **Fairness:** NREQ=3, all three reqs held continuously. Expect grant order 0,1,2,0,1,2 with no repeats; the pointer wraps 2→0.
- **Reset mid-operation:** assert rst_in for one cycle during BUSY. Expect all outputs 0 on the following cycle and no done_out. A subsequent 0x11*0x11 request returns 0x0121 with normal latency.
- **Multiplier busy in IDLE:** force mult_busy_in=1 while req_in[1] is set. Expect no ack and no start. After mult_busy_in drops, ack follows one cycle after the next sampling edge.

Source files
------------

// File: rtl/mult_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mult_arbiter
//  Purpose  : Round-robin arbiter and sequencer that shares one 8x8 sequential
//             multiplier among NREQ requesters. Operands are accepted over a
//             req/ack handshake, the multiplier is driven over its start/busy
//             interface, and each 16-bit product is returned with a
//             per-requester done pulse.
//  Ports    : clk_in, rst_in          clock / synchronous active-high reset
//             req_in[NREQ]            level request per requester
//             a_in, b_in[8*NREQ]      packed operands, slice i = [8i+7:8i]
//             ack_out[NREQ]           one-cycle operand-accept pulse
//             done_out[NREQ]          one-cycle product-ready pulse
//             y_out[16]               last captured product
//             busy_out                high whenever the FSM is not idle
//             mult_a_out, mult_b_out  operands to the multiplier
//             mult_start_out          start strobe to the multiplier
//             mult_busy_in            multiplier busy flag
//             mult_y_in[16]           multiplier product
//  Revision : 1.0  initial release
// ============================================================================
module mult_arbiter #(
    parameter int NREQ = 2
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [NREQ-1:0]     req_in,
    input  logic [8*NREQ-1:0]   a_in,
    input  logic [8*NREQ-1:0]   b_in,
    output logic [NREQ-1:0]     ack_out,
    output logic [NREQ-1:0]     done_out,
    output logic [15:0]         y_out,
    output logic                busy_out,
    output logic [7:0]          mult_a_out,
    output logic [7:0]          mult_b_out,
    output logic                mult_start_out,
    input  logic                mult_busy_in,
    input  logic [15:0]         mult_y_in
);

    localparam int c_IDX_W = (NREQ > 2) ? 2 : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NREQ - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_BUSY  = 2'd2;

    logic [1:0]          r_state;
    logic [c_IDX_W-1:0]  r_ptr;
    logic [c_IDX_W-1:0]  r_gnt;
    logic [NREQ-1:0]     r_ack;
    logic [NREQ-1:0]     r_done;
    logic [15:0]         r_y;
    logic                r_busy;
    logic [7:0]          r_mult_a;
    logic [7:0]          r_mult_b;
    logic                r_mult_start;

    logic                w_gnt_vld;
    logic [c_IDX_W-1:0]  w_gnt;
    logic [c_IDX_W-1:0]  w_ptr_nxt;
    logic [7:0]          w_a_sel;
    logic [7:0]          w_b_sel;

    // Requester index reached k steps above the pointer, wrapping modulo NREQ.
    function automatic logic [c_IDX_W-1:0] rr_idx(input logic [c_IDX_W-1:0] p,
                                                   input int k);
        int s;
        s = int'(p) + k;
        if (s >= NREQ) s = s - NREQ;
        return c_IDX_W'(s);
    endfunction

    // Scan from the farthest position back towards the pointer so that the
    // candidate closest to the pointer (in round-robin order) wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_in[rr_idx(r_ptr, k)]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = rr_idx(r_ptr, k);
            end
        end
    end

    always_comb begin
        w_ptr_nxt = (w_gnt == c_LAST_IDX) ? '0 : w_gnt + 1'b1;
        w_a_sel   = a_in[8*w_gnt +: 8];
        w_b_sel   = b_in[8*w_gnt +: 8];
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state      <= c_ST_IDLE;
            r_ptr        <= '0;
            r_gnt        <= '0;
            r_ack        <= '0;
            r_done       <= '0;
            r_y          <= '0;
            r_busy       <= 1'b0;
            r_mult_a     <= '0;
            r_mult_b     <= '0;
            r_mult_start <= 1'b0;
        end else begin
            // Handshake outputs are single-cycle pulses.
            r_ack  <= '0;
            r_done <= '0;
            case (r_state)
                c_ST_IDLE: begin
                    // The multiplier may still be busy from an operation this
                    // block did not track (e.g. shared reset release timing).
                    if (w_gnt_vld && !mult_busy_in) begin
                        r_mult_a     <= w_a_sel;
                        r_mult_b     <= w_b_sel;
                        r_mult_start <= 1'b1;
                        r_ack[w_gnt] <= 1'b1;
                        r_gnt        <= w_gnt;
                        r_ptr        <= w_ptr_nxt;
                        r_busy       <= 1'b1;
                        r_state      <= c_ST_START;
                    end
                end
                c_ST_START: begin
                    // The multiplier raises busy on the edge that sees start,
                    // so BUSY can begin watching it from the next cycle.
                    r_mult_start <= 1'b0;
                    r_state      <= c_ST_BUSY;
                end
                c_ST_BUSY: begin
                    if (!mult_busy_in) begin
                        r_y           <= mult_y_in;
                        r_done[r_gnt] <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_mult_start <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign ack_out        = r_ack;
    assign done_out       = r_done;
    assign y_out          = r_y;
    assign busy_out       = r_busy;
    assign mult_a_out     = r_mult_a;
    assign mult_b_out     = r_mult_b;
    assign mult_start_out = r_mult_start;

endmodule
`default_nettype wire

// File: tb/tb_mult_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_arbiter
//  Purpose  : Directed self-checking bench for mult_arbiter (NREQ = 3) with a
//             behavioural 10-cycle sequential multiplier attached.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mult_arbiter;

    localparam int NREQ = 3;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NREQ-1:0]    req = '0;
    logic [8*NREQ-1:0]  a_bus = '0;
    logic [8*NREQ-1:0]  b_bus = '0;
    logic [NREQ-1:0]    ack_out;
    logic [NREQ-1:0]    done_out;
    logic [15:0]        y_out;
    logic               busy_out;
    logic [7:0]         mult_a_out;
    logic [7:0]         mult_b_out;
    logic               mult_start_out;
    logic               mult_busy_in;
    logic [15:0]        mult_y_in;

    logic               m_busy;
    logic [3:0]         m_cnt;
    logic [15:0]        m_y;
    logic               force_busy = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mult_arbiter #(.NREQ(NREQ)) dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .req_in         (req),
        .a_in           (a_bus),
        .b_in           (b_bus),
        .ack_out        (ack_out),
        .done_out       (done_out),
        .y_out          (y_out),
        .busy_out       (busy_out),
        .mult_a_out     (mult_a_out),
        .mult_b_out     (mult_b_out),
        .mult_start_out (mult_start_out),
        .mult_busy_in   (mult_busy_in),
        .mult_y_in      (mult_y_in)
    );

    // Multiplier model: busy for 10 cycles after the edge that sees start.
    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_cnt  <= 4'd0;
            m_y    <= 16'h0;
        end else if (mult_start_out) begin
            m_busy <= 1'b1;
            m_cnt  <= 4'd10;
            m_y    <= {8'h00, mult_a_out} * {8'h00, mult_b_out};
        end else if (m_cnt != 4'd0) begin
            m_cnt <= m_cnt - 4'd1;
            if (m_cnt == 4'd1) m_busy <= 1'b0;
        end
    end

    assign mult_busy_in = m_busy | force_busy;
    assign mult_y_in    = m_y;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        do begin step(); n++; end while (ack_out == '0 && n < 40);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin step(); n++; end while (done_out == '0 && n < 40);
    endtask

    // One full transaction from a single requester.
    task automatic do_op(input int idx, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp_y, input string tag);
        int n;
        req[idx]          = 1'b1;
        a_bus[8*idx +: 8] = a;
        b_bus[8*idx +: 8] = b;
        wait_ack(n);
        check({tag, " ack"}, 32'(ack_out), 32'(1 << idx));
        check({tag, " start"}, 32'(mult_start_out), 32'd1);
        check({tag, " operands"}, {16'h0, mult_a_out, mult_b_out}, {16'h0, a, b});
        req[idx] = 1'b0;
        wait_done(n);
        check({tag, " latency"}, 32'(n), 32'd12);
        check({tag, " done"}, 32'(done_out), 32'(1 << idx));
        check({tag, " y"}, 32'(y_out), 32'(exp_y));
        check({tag, " busy falls"}, 32'(busy_out), 32'd0);
    endtask

    initial begin
        int n;
        int cnt;
        int prev;

        // Reset state
        do_reset();
        check("reset y", 32'(y_out), 32'd0);
        check("reset ctl", {22'h0, ack_out, done_out, busy_out, mult_start_out}, 32'd0);
        check("reset ops", {16'h0, mult_a_out, mult_b_out}, 32'd0);

        // Single request
        do_op(0, 8'h0C, 8'h0D, 16'h009C, "single");

        // Operand extremes
        do_op(1, 8'hFF, 8'hFF, 16'hFE01, "ffxff");
        do_op(2, 8'h00, 8'hA5, 16'h0000, "zero");
        do_op(0, 8'h80, 8'h02, 16'h0100, "pow2");

        // Simultaneous requests after reset: requester 0 wins, 1 follows
        do_reset();
        req          = 3'b011;
        a_bus[7:0]   = 8'h03; b_bus[7:0]  = 8'h05;
        a_bus[15:8]  = 8'h07; b_bus[15:8] = 8'h09;
        wait_ack(n);
        check("simul first ack", 32'(ack_out), 32'b001);
        req[0] = 1'b0;
        wait_done(n);
        check("simul done0", 32'(done_out), 32'b001);
        check("simul y0", 32'(y_out), 32'h000F);
        wait_ack(n);
        check("simul ack1 gap", 32'(n), 32'd1);
        check("simul second ack", 32'(ack_out), 32'b010);
        req[1] = 1'b0;
        wait_done(n);
        check("simul done1", 32'(done_out), 32'b010);
        check("simul y1", 32'(y_out), 32'h003F);

        // Fairness: all three requests held continuously
        do_reset();
        a_bus = {8'h03, 8'h02, 8'h01};
        b_bus = {8'h10, 8'h10, 8'h10};
        req   = 3'b111;
        prev  = -1;
        for (int k = 0; k < 6; k++) begin
            wait_ack(n);
            check("fair grant", 32'(ack_out), 32'(1 << (k % 3)));
            check("fair opa", 32'(mult_a_out), 32'(k % 3 + 1));
            if (k == 5) req = '0;
            wait_done(n);
            check("fair y", 32'(y_out), 32'((k % 3 + 1) * 16));
        end

        // Reset mid-operation
        do_reset();
        req[0] = 1'b1; a_bus[7:0] = 8'h55; b_bus[7:0] = 8'h02;
        wait_ack(n);
        req[0] = 1'b0;
        for (int k = 0; k < 5; k++) step();
        check("midrst busy before", 32'(busy_out), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst y", 32'(y_out), 32'd0);
        check("midrst ctl", {22'h0, ack_out, done_out, busy_out, mult_start_out}, 32'd0);
        check("midrst ops", {16'h0, mult_a_out, mult_b_out}, 32'd0);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (done_out != '0) cnt++;
        end
        check("midrst no done", 32'(cnt), 32'd0);
        do_op(0, 8'h11, 8'h11, 16'h0121, "after rst");

        // Multiplier busy while idle blocks launch
        force_busy = 1'b1;
        req[1] = 1'b1; a_bus[15:8] = 8'h06; b_bus[15:8] = 8'h07;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (ack_out != '0 || mult_start_out) cnt++;
        end
        check("mbusy blocked", 32'(cnt), 32'd0);
        force_busy = 1'b0;
        wait_ack(n);
        check("mbusy ack delay", 32'(n), 32'd1);
        check("mbusy ack", 32'(ack_out), 32'b010);
        req[1] = 1'b0;
        wait_done(n);
        check("mbusy latency", 32'(n), 32'd12);
        check("mbusy y", 32'(y_out), 32'h002A);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
